strela_obi_rr_arbiter: RTL and testbench

STRELA_OBI_RR_ARBITER -- requirements
Module: strela_obi_rr_arbiter

---
 rtl/strela_obi_rr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_strela_obi_rr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strela_obi_rr_arbiter.sv
// Round-robin arbiter that shares one OBI slave port among NUM_MASTERS
// masters. It holds a stalled request until it is granted, limits the number
// of outstanding transactions, and sends each response back to its
// originating master in grant order.
module strela_obi_rr_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    // master side
    input  logic [NUM_MASTERS-1:0]               m_req_i,
    output logic [NUM_MASTERS-1:0]               m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_addr_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_wdata_i,
    output logic [NUM_MASTERS-1:0]               m_rvalid_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_rdata_o,
    // slave side
    output logic                                 s_req_o,
    input  logic                                 s_gnt_i,
    output logic [ADDR_WIDTH-1:0]                s_addr_o,
    output logic                                 s_we_o,
    output logic [DATA_WIDTH/8-1:0]              s_be_o,
    output logic [DATA_WIDTH-1:0]                s_wdata_o,
    input  logic                                 s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                s_rdata_i,
    // status
    output logic                                 busy_o,
    output logic                                 err_o
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int FIFO_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [PTR_W-1:0]  LAST_MASTER = PTR_W'(NUM_MASTERS - 1);
    localparam logic [FIFO_W-1:0] LAST_SLOT   = FIFO_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT     = CNT_W'(MAX_OUTSTANDING);

    // arbitration state
    logic [PTR_W-1:0]  r_ptr;
    logic              r_locked;
    logic [PTR_W-1:0]  r_lock_idx;
    // outstanding-ID FIFO state
    logic [PTR_W-1:0]  r_fifo [MAX_OUTSTANDING];
    logic [FIFO_W-1:0] r_wr;
    logic [FIFO_W-1:0] r_rd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic              w_any_req;
    logic              w_lock_hold;
    logic [PTR_W-1:0]  w_sel;
    logic              w_hs;
    logic              w_pop;
    logic              w_spurious;

    assign w_any_req   = |m_req_i;
    // A lock only holds while its master keeps requesting; dropping req
    // releases it and lets arbitration run in the same cycle.
    assign w_lock_hold = r_locked & m_req_i[r_lock_idx];

    // Winner selection: the locked master, else the first requester at or after r_ptr
    always_comb begin
        // NOTE: default assignment first so every path drives w_sel and no latch is inferred.
        w_sel = r_ptr;
        if (w_lock_hold) begin
            w_sel = r_lock_idx;
        end else begin
            // Walk from the farthest offset down so the closest requester is assigned last.
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (m_req_i[(int'(r_ptr) + i) % NUM_MASTERS]) begin
                    w_sel = PTR_W'((int'(r_ptr) + i) % NUM_MASTERS);
                end
            end
        end
    end

    // Request is held low during reset and whenever the outstanding budget is used up.
    assign s_req_o    = rst_ni & w_any_req & (r_cnt < MAX_CNT);
    assign w_hs       = s_req_o & s_gnt_i;
    assign w_pop      = s_rvalid_i & (r_cnt != '0);
    assign w_spurious = s_rvalid_i & (r_cnt == '0);

    assign s_addr_o  = m_addr_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_we_o    = m_we_i[w_sel];
    assign s_be_o    = m_be_i[int'(w_sel)*BE_WIDTH +: BE_WIDTH];
    assign s_wdata_o = m_wdata_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];

    assign m_rdata_o = {NUM_MASTERS{s_rdata_i}};
    assign busy_o    = (r_cnt != '0);
    assign err_o     = r_err;

    // One-hot grant to the winner, only in a handshake cycle
    always_comb begin
        m_gnt_o = '0;
        if (w_hs) begin
            m_gnt_o[w_sel] = 1'b1;
        end
    end

    // Route a response to the master at the FIFO head
    always_comb begin
        m_rvalid_o = '0;
        if (rst_ni && w_pop) begin
            m_rvalid_o[r_fifo[r_rd]] = 1'b1;
        end
    end

    // Priority pointer and stall lock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
            if (w_hs) begin
                r_ptr    <= (w_sel == LAST_MASTER) ? '0 : w_sel + 1'b1;
                r_locked <= 1'b0;
            end else if (s_req_o) begin
                r_locked   <= 1'b1;
                r_lock_idx <= w_sel;
            end else if (!w_lock_hold) begin
                r_locked <= 1'b0;
            end
        end
    end

    // FIFO pointers, outstanding count and sticky error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_hs) begin
                r_wr <= (r_wr == LAST_SLOT) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == LAST_SLOT) ? '0 : r_rd + 1'b1;
            end
            case ({w_hs, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    // ID storage for granted transactions
    always_ff @(posedge clk_i) begin
        // NOTE: entries carry no reset; they are only read when r_cnt marks them valid.
        if (w_hs) begin
            r_fifo[r_wr] <= w_sel;
        end
    end

endmodule

// File: tb/tb_strela_obi_rr_arbiter.sv
// Self-checking bench for strela_obi_rr_arbiter: directed scenarios followed
// by random traffic, all checked against a queue-based reference model.
module tb_strela_obi_rr_arbiter;

    localparam int N  = 4;
    localparam int MO = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      m_req_i = '0;
    logic [N-1:0]      m_gnt_o;
    logic [N*AW-1:0]   m_addr_i = '0;
    logic [N-1:0]      m_we_i = '0;
    logic [N*BW-1:0]   m_be_i = '0;
    logic [N*DW-1:0]   m_wdata_i = '0;
    logic [N-1:0]      m_rvalid_o;
    logic [N*DW-1:0]   m_rdata_o;
    logic              s_req_o;
    logic              s_gnt_i = 1'b0;
    logic [AW-1:0]     s_addr_o;
    logic              s_we_o;
    logic [BW-1:0]     s_be_o;
    logic [DW-1:0]     s_wdata_o;
    logic              s_rvalid_i = 1'b0;
    logic [DW-1:0]     s_rdata_i = '0;
    logic              busy_o;
    logic              err_o;

    strela_obi_rr_arbiter #(
        .NUM_MASTERS(N), .MAX_OUTSTANDING(MO), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
        .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: priority pointer, locked master (-1 = none),
    // queue of granted IDs awaiting a response, sticky error flag.
    int     mdl_ptr;
    int     mdl_lock;
    int     mdl_q[$];
    bit     mdl_err;
    // What the current cycle decided, applied at the next clock edge.
    int           cyc_w;
    bit           cyc_hs, cyc_sreq, cyc_pop, cyc_spur;
    logic [N-1:0] cyc_req;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        mdl_ptr  = 0;
        mdl_lock = -1;
        mdl_q.delete();
        mdl_err  = 1'b0;
    endtask

    // Apply inputs just after an edge, then check all outputs mid-cycle.
    task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv,
                         input logic [DW-1:0] rd);
        int           w;
        bit           sreq, hs;
        logic [N-1:0] eg, er;
        m_req_i    = req;
        s_gnt_i    = gnt;
        s_rvalid_i = rv;
        s_rdata_i  = rd;
        for (int k = 0; k < N; k++) begin
            m_addr_i[k*AW +: AW]  = $urandom;
            m_we_i[k]             = 1'($urandom_range(0, 1));
            m_be_i[k*BW +: BW]    = BW'($urandom);
            m_wdata_i[k*DW +: DW] = $urandom;
        end
        #4;
        w = -1;
        if (mdl_lock >= 0 && req[mdl_lock]) begin
            w = mdl_lock;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w < 0 && req[(mdl_ptr + i) % N]) w = (mdl_ptr + i) % N;
            end
        end
        sreq = (req != '0) && (mdl_q.size() < MO);
        hs   = sreq && gnt;
        eg   = '0;
        if (hs) eg[w] = 1'b1;
        er   = '0;
        if (rv && mdl_q.size() > 0) er[mdl_q[0]] = 1'b1;
        check("s_req", 128'(s_req_o), 128'(sreq));
        check("m_gnt", 128'(m_gnt_o), 128'(eg));
        check("m_rvalid", 128'(m_rvalid_o), 128'(er));
        check("busy", 128'(busy_o), 128'(mdl_q.size() != 0));
        check("err", 128'(err_o), 128'(mdl_err));
        check("m_rdata", 128'(m_rdata_o), 128'({N{rd}}));
        if (w >= 0) begin
            check("s_addr", 128'(s_addr_o), 128'(m_addr_i[w*AW +: AW]));
            check("s_we", 128'(s_we_o), 128'(m_we_i[w]));
            check("s_be", 128'(s_be_o), 128'(m_be_i[w*BW +: BW]));
            check("s_wdata", 128'(s_wdata_o), 128'(m_wdata_i[w*DW +: DW]));
        end
        cyc_w    = w;
        cyc_hs   = hs;
        cyc_sreq = sreq;
        cyc_pop  = rv && (mdl_q.size() > 0);
        cyc_spur = rv && (mdl_q.size() == 0);
        cyc_req  = req;
    endtask

    // Advance one clock edge and update the model with this cycle's decisions.
    task automatic tick();
        @(posedge clk_i);
        if (cyc_pop) void'(mdl_q.pop_front());
        if (cyc_spur) mdl_err = 1'b1;
        if (cyc_hs) begin
            mdl_q.push_back(cyc_w);
            mdl_ptr  = (cyc_w + 1) % N;
            mdl_lock = -1;
        end else if (cyc_sreq) begin
            mdl_lock = cyc_w;
        end else if (mdl_lock >= 0 && !cyc_req[mdl_lock]) begin
            mdl_lock = -1;
        end
        #1;
    endtask

    // Reset with all requests and a response pending; everything must stay quiet.
    task automatic do_reset();
        rst_ni     = 1'b0;
        m_req_i    = '1;
        s_gnt_i    = 1'b1;
        s_rvalid_i = 1'b1;
        #2;
        check("rst_s_req", 128'(s_req_o), 128'(1'b0));
        check("rst_m_gnt", 128'(m_gnt_o), 128'(4'b0000));
        check("rst_m_rvalid", 128'(m_rvalid_o), 128'(4'b0000));
        check("rst_busy", 128'(busy_o), 128'(1'b0));
        check("rst_err", 128'(err_o), 128'(1'b0));
        mdl_clear();
        m_req_i    = '0;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        mdl_clear();
        #1;
        do_reset();

        // All masters requesting: grants rotate 0,1,2,3,0; responses one cycle later.
        drive(4'b1111, 1'b1, 1'b0, 32'h0);
        check("rr_gnt0", 128'(m_gnt_o), 128'(4'b0001));
        tick();
        for (int i = 1; i < 5; i++) begin
            drive(4'b1111, 1'b1, 1'b1, $urandom);
            check("rr_gnt", 128'(m_gnt_o), 128'(1 << order[i]));
            check("rr_rvalid", 128'(m_rvalid_o), 128'(1 << order[i-1]));
            tick();
        end
        drive(4'b0000, 1'b0, 1'b1, $urandom);
        check("rr_rvalid_last", 128'(m_rvalid_o), 128'(4'b0001));
        tick();

        // Lock: master 2 stalls, master 0 (higher priority at ptr=0) must wait.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b0, 1'b0, 32'h0);
            check("lock_stall_gnt", 128'(m_gnt_o), 128'(4'b0000));
            tick();
        end
        drive(4'b0101, 1'b0, 1'b0, 32'h0);
        check("lock_addr", 128'(s_addr_o), 128'(m_addr_i[2*AW +: AW]));
        tick();
        drive(4'b0101, 1'b1, 1'b0, 32'h0);
        check("lock_gnt2", 128'(m_gnt_o), 128'(4'b0100));
        tick();
        drive(4'b0101, 1'b1, 1'b0, 32'h0);
        check("lock_next_gnt0", 128'(m_gnt_o), 128'(4'b0001));
        tick();
        drive(4'b0000, 1'b0, 1'b1, 32'h0);
        tick();
        drive(4'b0000, 1'b0, 1'b1, 32'h0);
        tick();

        // Locked master drops its request: arbitration resumes the same cycle.
        drive(4'b0100, 1'b0, 1'b0, 32'h0);
        tick();
        drive(4'b0001, 1'b1, 1'b0, 32'h0);
        check("unlock_gnt0", 128'(m_gnt_o), 128'(4'b0001));
        tick();
        drive(4'b0000, 1'b0, 1'b1, 32'h0);
        tick();

        // Outstanding limit: full after two grants, no same-cycle bypass on rvalid.
        drive(4'b0001, 1'b1, 1'b0, 32'h0);
        tick();
        drive(4'b0001, 1'b1, 1'b0, 32'h0);
        tick();
        drive(4'b0001, 1'b1, 1'b1, 32'h0);
        check("full_s_req", 128'(s_req_o), 128'(1'b0));
        check("full_busy", 128'(busy_o), 128'(1'b1));
        tick();
        drive(4'b0001, 1'b0, 1'b0, 32'h0);
        check("refill_s_req", 128'(s_req_o), 128'(1'b1));
        tick();
        drive(4'b0000, 1'b0, 1'b1, 32'h0);
        tick();

        // In-order responses to masters 1 then 3.
        drive(4'b0010, 1'b1, 1'b0, 32'h0);
        tick();
        drive(4'b1000, 1'b1, 1'b0, 32'h0);
        tick();
        drive(4'b0000, 1'b0, 1'b1, 32'hA5A5_0001);
        check("order_rv1", 128'(m_rvalid_o), 128'(4'b0010));
        check("order_rd1", 128'(m_rdata_o[1*DW +: DW]), 128'(32'hA5A5_0001));
        tick();
        drive(4'b0000, 1'b0, 1'b1, 32'h5A5A_0003);
        check("order_rv3", 128'(m_rvalid_o), 128'(4'b1000));
        check("order_rd3", 128'(m_rdata_o[3*DW +: DW]), 128'(32'h5A5A_0003));
        tick();

        // Spurious rvalid: nothing routed, sticky error.
        drive(4'b0000, 1'b0, 1'b1, 32'h0);
        check("spur_rvalid", 128'(m_rvalid_o), 128'(4'b0000));
        check("spur_err_before", 128'(err_o), 128'(1'b0));
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, 1'b0, 1'b0, 32'h0);
            check("spur_err_sticky", 128'(err_o), 128'(1'b1));
            tick();
        end

        // Asynchronous reset with cnt=2, ptr=2.
        do_reset();
        drive(4'b0011, 1'b1, 1'b0, 32'h0);
        tick();
        drive(4'b0011, 1'b1, 1'b0, 32'h0);
        check("pre_rst_gnt1", 128'(m_gnt_o), 128'(4'b0010));
        tick();
        m_req_i    = 4'b1111;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        #1;
        check("pre_rst_busy", 128'(busy_o), 128'(1'b1));
        #1;
        rst_ni = 1'b0;
        #1;
        check("async_busy", 128'(busy_o), 128'(1'b0));
        check("async_s_req", 128'(s_req_o), 128'(1'b0));
        mdl_clear();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        drive(4'b1111, 1'b1, 1'b0, 32'h0);
        check("post_rst_gnt0", 128'(m_gnt_o), 128'(4'b0001));
        tick();
        drive(4'b0000, 1'b0, 1'b1, 32'h0);
        tick();
        drive(4'b0000, 1'b0, 1'b1, 32'h0);
        check("late_rvalid", 128'(m_rvalid_o), 128'(4'b0000));
        tick();
        drive(4'b0000, 1'b0, 1'b0, 32'h0);
        check("late_err", 128'(err_o), 128'(1'b1));
        tick();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), $urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
